// File: rtl/result_arbiter_if.sv
// Handshake bundle between the validator core array, the outlier FIFO and result_arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system.
interface result_arbiter_if #(
  parameter int N           = 16,
  parameter int CORE_NUMBER = 16
);
  logic                       start;
  logic [2*N-1:0]             point_cloud_size;
  logic [CORE_NUMBER-1:0]     core_done;
  logic [CORE_NUMBER-1:0]     core_outlier;
  logic [2*N*CORE_NUMBER-1:0] core_pos;
  logic                       fifo_full;
  logic [CORE_NUMBER-1:0]     core_ack;
  logic                       fifo_wr_en;
  logic [2*N-1:0]             fifo_din;
  logic [2*N-1:0]             processed_count;
  logic [2*N-1:0]             outlier_count;
  logic                       busy;
  logic                       done;

  modport master (
    output start, point_cloud_size, core_done, core_outlier, core_pos, fifo_full,
    input  core_ack, fifo_wr_en, fifo_din, processed_count, outlier_count, busy, done
  );

  modport slave (
    input  start, point_cloud_size, core_done, core_outlier, core_pos, fifo_full,
    output core_ack, fifo_wr_en, fifo_din, processed_count, outlier_count, busy, done
  );
endinterface

// File: rtl/result_arbiter.sv
// Round-robin arbiter granting one finished validator core per cycle, forwarding
// outlier positions to the FIFO and counting results until the run size is reached.
module result_arbiter #(
  parameter int N           = 16,
  parameter int CORE_NUMBER = 16,
  parameter int PTR_W       = 4
) (
  input  logic            clock,
  input  logic            reset,
  result_arbiter_if.slave arb_if
);
  localparam int W = 2 * N;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q;
  logic [PTR_W-1:0]       rr_ptr_q;
  logic [W-1:0]           size_q;
  logic [W-1:0]           processed_q;
  logic [W-1:0]           outlier_q;
  logic [W-1:0]           fifo_din_q;
  logic [CORE_NUMBER-1:0] core_ack_q;
  logic                   fifo_wr_en_q;
  logic                   busy_q;
  logic                   done_q;

  logic [CORE_NUMBER-1:0] elig_s;
  logic [PTR_W-1:0]       idx_s;
  logic                   hit_s;
  logic                   found_s;
  logic [PTR_W-1:0]       win_s;
  logic                   win_outlier_s;
  logic [W-1:0]           win_pos_s;
  logic                   grant_s;
  logic [PTR_W-1:0]       rr_next_d;
  logic [W-1:0]           processed_d;

  // Winner search: a core acked last cycle is masked so its held request is not counted twice.
  always_comb begin
    elig_s  = arb_if.core_done & ~core_ack_q;
    idx_s   = '0;
    hit_s   = 1'b0;
    found_s = 1'b0;
    win_s   = '0;
    for (int i = 0; i < CORE_NUMBER; i++) begin
      idx_s   = PTR_W'((int'(rr_ptr_q) + i) % CORE_NUMBER);
      hit_s   = ~found_s & elig_s[idx_s];
      win_s   = hit_s ? idx_s : win_s;
      found_s = found_s | hit_s;
    end
  end

  // Winner attributes; an outlier winner facing a full FIFO stalls the whole arbiter.
  always_comb begin
    win_outlier_s = arb_if.core_outlier[win_s];
    win_pos_s     = '0;
    for (int j = 0; j < CORE_NUMBER; j++) begin
      win_pos_s = win_pos_s | ({W{PTR_W'(j) == win_s}} & arb_if.core_pos[j*W +: W]);
    end
    grant_s     = found_s & ~(win_outlier_s & arb_if.fifo_full);
    rr_next_d   = (win_s == PTR_W'(CORE_NUMBER - 1)) ? '0 : win_s + PTR_W'(1);
    processed_d = processed_q + W'(1);
  end

  // Run-control FSM with all outputs registered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      size_q       <= '0;
      processed_q  <= '0;
      outlier_q    <= '0;
      fifo_din_q   <= '0;
      core_ack_q   <= '0;
      fifo_wr_en_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      core_ack_q   <= '0;
      fifo_wr_en_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (arb_if.start) begin
            size_q      <= arb_if.point_cloud_size;
            processed_q <= '0;
            outlier_q   <= '0;
            rr_ptr_q    <= '0;
            if (arb_if.point_cloud_size == '0) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end
        RUN: begin
          if (grant_s) begin
            core_ack_q  <= CORE_NUMBER'(1) << win_s;
            processed_q <= processed_d;
            rr_ptr_q    <= rr_next_d;
            if (win_outlier_s) begin
              fifo_wr_en_q <= 1'b1;
              fifo_din_q   <= win_pos_s;
              outlier_q    <= outlier_q + W'(1);
            end
            // Completion lands on the same edge as the final grant.
            if (processed_d == size_q) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign arb_if.core_ack        = core_ack_q;
  assign arb_if.fifo_wr_en      = fifo_wr_en_q;
  assign arb_if.fifo_din        = fifo_din_q;
  assign arb_if.processed_count = processed_q;
  assign arb_if.outlier_count   = outlier_q;
  assign arb_if.busy            = busy_q;
  assign arb_if.done            = done_q;
endmodule

// File: tb/tb_result_arbiter.sv
// Directed bench for result_arbiter with 4 cores: expected outputs are queued per step
// and popped for comparison one cycle later, after the registered outputs settle.
module tb_result_arbiter;
  localparam int N  = 16;
  localparam int CN = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  result_arbiter_if #(.N(N), .CORE_NUMBER(CN)) bus ();

  result_arbiter #(.N(N), .CORE_NUMBER(CN), .PTR_W(2)) dut (
    .clock  (clk),
    .reset  (rst_n),
    .arb_if (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [3:0]  ack;
    logic        wr;
    logic [31:0] din;
    logic [31:0] pc;
    logic [31:0] oc;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] ack, input logic wr,
                            input logic [31:0] din, input logic [31:0] pc,
                            input logic [31:0] oc, input logic busy, input logic done);
    exp_t e;
    e.tag = tag; e.ack = ack; e.wr = wr; e.din = din;
    e.pc = pc; e.oc = oc; e.busy = busy; e.done = done;
    sb_q.push_back(e);
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, ".ack"},  32'(bus.core_ack),        32'(e.ack));
      chk({e.tag, ".wr"},   32'(bus.fifo_wr_en),      32'(e.wr));
      chk({e.tag, ".din"},  bus.fifo_din,             e.din);
      chk({e.tag, ".pc"},   bus.processed_count,      e.pc);
      chk({e.tag, ".oc"},   bus.outlier_count,        e.oc);
      chk({e.tag, ".busy"}, 32'(bus.busy),            32'(e.busy));
      chk({e.tag, ".done"}, 32'(bus.done),            32'(e.done));
    end
  endtask

  task automatic step(input string tag, input logic [3:0] ack, input logic wr,
                      input logic [31:0] din, input logic [31:0] pc,
                      input logic [31:0] oc, input logic busy, input logic done);
    expect_out(tag, ack, wr, din, pc, oc, busy, done);
    @(posedge clk);
    #1;
    compare_front();
  endtask

  task automatic drive(input logic st, input logic [31:0] sz, input logic [3:0] dn,
                       input logic [3:0] outl, input logic ff);
    bus.start            = st;
    bus.point_cloud_size = sz;
    bus.core_done        = dn;
    bus.core_outlier     = outl;
    bus.fifo_full        = ff;
  endtask

  initial begin
    bus.core_pos = '0;
    drive(1'b0, 32'd0, 4'b0000, 4'b0000, 1'b0);
    #2;
    expect_out("reset", 4'b0000, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    compare_front();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Inlier then outlier from cores 0 and 1.
    drive(1'b1, 32'd3, 4'b0000, 4'b0000, 1'b0);
    step("t1_start", 4'b0000, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    bus.core_pos[63:32] = 32'd7;
    drive(1'b0, 32'd0, 4'b0011, 4'b0010, 1'b0);
    step("t1_c2", 4'b0001, 1'b0, 32'd0, 32'd1, 32'd0, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 4'b0010, 4'b0010, 1'b0);
    step("t1_c3", 4'b0010, 1'b1, 32'd7, 32'd2, 32'd1, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 4'b0000, 4'b0000, 1'b0);
    step("t1_idle", 4'b0000, 1'b0, 32'd7, 32'd2, 32'd1, 1'b1, 1'b0);

    // Outlier core 2 stalled by fifo_full; inlier core 0 must not overtake it.
    bus.core_pos[95:64] = 32'h1234;
    drive(1'b0, 32'd0, 4'b0101, 4'b0100, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step("t3_stall", 4'b0000, 1'b0, 32'd7, 32'd2, 32'd1, 1'b1, 1'b0);
    end
    drive(1'b0, 32'd0, 4'b0101, 4'b0100, 1'b0);
    step("t3_release", 4'b0100, 1'b1, 32'h1234, 32'd3, 32'd2, 1'b0, 1'b1);
    drive(1'b0, 32'd0, 4'b0001, 4'b0000, 1'b0);
    step("t3_done_hold", 4'b0000, 1'b0, 32'h1234, 32'd3, 32'd2, 1'b0, 1'b1);

    // All four cores requesting: fair rotation over ten grants.
    drive(1'b1, 32'd10, 4'b1111, 4'b0000, 1'b0);
    step("t2_start", 4'b0000, 1'b0, 32'h1234, 32'd0, 32'd0, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 4'b1111, 4'b0000, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step("t2_rr", 4'(4'b0001 << (k % 4)), 1'b0, 32'h1234, 32'(k + 1), 32'd0,
           (k == 9) ? 1'b0 : 1'b1, (k == 9) ? 1'b1 : 1'b0);
    end
    step("t2_after", 4'b0000, 1'b0, 32'h1234, 32'd10, 32'd0, 1'b0, 1'b1);

    // Size 5, start ignored mid-run, no acks after done, restart clears counts.
    drive(1'b1, 32'd5, 4'b1111, 4'b0000, 1'b0);
    step("t4_start", 4'b0000, 1'b0, 32'h1234, 32'd0, 32'd0, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 4'b1111, 4'b0000, 1'b0);
    step("t4_g1", 4'b0001, 1'b0, 32'h1234, 32'd1, 32'd0, 1'b1, 1'b0);
    drive(1'b1, 32'd0, 4'b1111, 4'b0000, 1'b0);
    step("t4_g2_start_ignored", 4'b0010, 1'b0, 32'h1234, 32'd2, 32'd0, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 4'b1111, 4'b0000, 1'b0);
    step("t4_g3", 4'b0100, 1'b0, 32'h1234, 32'd3, 32'd0, 1'b1, 1'b0);
    step("t4_g4", 4'b1000, 1'b0, 32'h1234, 32'd4, 32'd0, 1'b1, 1'b0);
    step("t4_g5_done", 4'b0001, 1'b0, 32'h1234, 32'd5, 32'd0, 1'b0, 1'b1);
    step("t4_nomore_a", 4'b0000, 1'b0, 32'h1234, 32'd5, 32'd0, 1'b0, 1'b1);
    step("t4_nomore_b", 4'b0000, 1'b0, 32'h1234, 32'd5, 32'd0, 1'b0, 1'b1);
    drive(1'b1, 32'd7, 4'b1111, 4'b0000, 1'b0);
    step("t4_restart", 4'b0000, 1'b0, 32'h1234, 32'd0, 32'd0, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 4'b1111, 4'b0000, 1'b0);
    step("t5_g1", 4'b0001, 1'b0, 32'h1234, 32'd1, 32'd0, 1'b1, 1'b0);
    step("t5_g2", 4'b0010, 1'b0, 32'h1234, 32'd2, 32'd0, 1'b1, 1'b0);
    step("t5_g3", 4'b0100, 1'b0, 32'h1234, 32'd3, 32'd0, 1'b1, 1'b0);

    // Asynchronous reset mid-run, checked between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("t5_async", 4'b0000, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    compare_front();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step("t5_no_start", 4'b0000, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    end

    // Zero-size run goes straight to done.
    drive(1'b1, 32'd0, 4'b1111, 4'b0000, 1'b0);
    step("t6_start", 4'b0000, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    drive(1'b0, 32'd0, 4'b1111, 4'b0000, 1'b0);
    step("t6_hold", 4'b0000, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
